word_serializer_32to8: RTL and testbench

WORD_SERIALIZER_32TO8 -- requirements
Module: word_serializer_32to8

---
 rtl/word_serializer_32to8_pkg.sv | 25 ++
 rtl/word_serializer_32to8_byte_select.sv | 19 +
 rtl/word_serializer_32to8.sv | 104 ++++++++++
 tb/tb_word_serializer_32to8.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_32to8_pkg.sv
// Shared types and constants for the 32-to-8 word serializer.
// Optional parity output is enabled by defining WORD_SERIALIZER_PARITY_EN.
package word_serializer_32to8_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend
  } state_e;

  // Map a logical byte index to its physical lane within the word.
  function automatic logic [IDX_W-1:0] byte_lane(input logic [IDX_W-1:0] idx,
                                                 input bit lsb_first);
    if (lsb_first) begin
      return idx;
    end
    return IDX_W'(BYTES_PER_WORD - 1) - idx;
  endfunction

endpackage

// File: rtl/word_serializer_32to8_byte_select.sv
// Combinational byte picker: returns one byte of a word by logical index and send order.
module word_serializer_32to8_byte_select
  import word_serializer_32to8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [BYTE_W-1:0] byte_out
);

  logic [IDX_W-1:0] lane;

  always_comb begin
    lane     = byte_lane(idx, LSB_FIRST);
    byte_out = word[lane*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/word_serializer_32to8.sv
// Pops 32-bit words from an upstream FIFO and streams them out as bytes with a valid/ready port.
// Defining WORD_SERIALIZER_PARITY_EN adds an out_parity output (XOR of out_data).
module word_serializer_32to8
  import word_serializer_32to8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_rd_data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       byte_cnt
`ifdef WORD_SERIALIZER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  state_e            state_q;
  logic [WORD_W-1:0] hold_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic [15:0]       cnt_q;

  logic              handshake;
  logic              last_byte;
  logic [BYTE_W-1:0] sel_byte;

  assign handshake = valid_q && out_ready;
  assign last_byte = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

  // Pop is gated by rst_n so the FIFO is never drained while held in reset.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle:  fifo_rd_en = !fifo_empty;
        StSend:  fifo_rd_en = handshake && last_byte && !fifo_empty;
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            state_q <= StFetch;
          end
        end
        StFetch: begin
          hold_q  <= fifo_rd_data;
          idx_q   <= '0;
          valid_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (handshake) begin
            cnt_q <= cnt_q + 16'd1;
            if (!last_byte) begin
              idx_q <= idx_q + IDX_W'(1);
            end else begin
              valid_q <= 1'b0;
              state_q <= fifo_empty ? StIdle : StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  word_serializer_32to8_byte_select #(
    .LSB_FIRST (LSB_FIRST)
  ) u_byte_select (
    .word     (hold_q),
    .idx      (idx_q),
    .byte_out (sel_byte)
  );

  assign out_valid = valid_q;
  assign busy      = (state_q != StIdle);
  assign byte_cnt  = cnt_q;

`ifdef WORD_SERIALIZER_PARITY_EN
  assign out_data   = sel_byte;
  assign out_parity = ^sel_byte;
`else
  assign out_data   = sel_byte;
`endif

endmodule

// File: tb/tb_word_serializer_32to8.sv
// Bench for word_serializer_32to8: an LSB-first and an MSB-first instance share one FIFO model
// and are checked every cycle against a byte-stream reference model.
module tb_word_serializer_32to8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        out_ready = 1'b0;
  logic [31:0] fifo_rd_data = '0;

  logic        rd_a, rd_b, val_a, val_b, busy_a, busy_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] cnt_a, cnt_b;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic        par_a, par_b;
`endif

  always #5 clk = ~clk;

  word_serializer_32to8 #(
    .LSB_FIRST (1'b1)
  ) dut_lsb (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (rd_a),
    .fifo_rd_data (fifo_rd_data),
    .out_data     (data_a),
    .out_valid    (val_a),
    .out_ready    (out_ready),
    .busy         (busy_a),
    .byte_cnt     (cnt_a)
`ifdef WORD_SERIALIZER_PARITY_EN
    ,
    .out_parity   (par_a)
`endif
  );

  word_serializer_32to8 #(
    .LSB_FIRST (1'b0)
  ) dut_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (rd_b),
    .fifo_rd_data (fifo_rd_data),
    .out_data     (data_b),
    .out_valid    (val_b),
    .out_ready    (out_ready),
    .busy         (busy_b),
    .byte_cnt     (cnt_b)
`ifdef WORD_SERIALIZER_PARITY_EN
    ,
    .out_parity   (par_b)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: words waiting upstream, expected byte streams, and transfer progress.
  logic [31:0] word_q[$];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int          bytes_left = 0;
  bit          fetch_pending = 1'b0;
  logic [15:0] cnt_m = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    word_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model past the rising edge.
  task automatic step();
    bit          exp_rd;
    bit          hs;
    logic [31:0] w;
    @(negedge clk);
    exp_rd = !fifo_empty && !fetch_pending &&
             (bytes_left == 0 || (bytes_left == 1 && out_ready));
    hs     = (bytes_left > 0) && out_ready;
    check_eq("rd_en_lsb", 32'(rd_a), 32'(exp_rd));
    check_eq("rd_en_msb", 32'(rd_b), 32'(exp_rd));
    check_eq("valid_lsb", 32'(val_a), 32'(bytes_left > 0));
    check_eq("valid_msb", 32'(val_b), 32'(bytes_left > 0));
    check_eq("busy_lsb", 32'(busy_a), 32'(fetch_pending || bytes_left > 0));
    check_eq("busy_msb", 32'(busy_b), 32'(fetch_pending || bytes_left > 0));
    check_eq("byte_cnt_lsb", 32'(cnt_a), 32'(cnt_m));
    check_eq("byte_cnt_msb", 32'(cnt_b), 32'(cnt_m));
    if (bytes_left > 0 && exp_a.size() > 0) begin
      check_eq("data_lsb", 32'(data_a), 32'(exp_a[0]));
      check_eq("data_msb", 32'(data_b), 32'(exp_b[0]));
`ifdef WORD_SERIALIZER_PARITY_EN
      check_eq("parity_lsb", 32'(par_a), 32'(^exp_a[0]));
      check_eq("parity_msb", 32'(par_b), 32'(^exp_b[0]));
`endif
    end
    @(posedge clk);
    #1;
    if (fetch_pending) begin
      bytes_left    = 4;
      fetch_pending = 1'b0;
    end else if (hs) begin
      bytes_left--;
    end
    if (hs) begin
      void'(exp_a.pop_front());
      void'(exp_b.pop_front());
      cnt_m++;
    end
    if (exp_rd) begin
      w            = word_q.pop_front();
      fifo_rd_data = w;
      for (int i = 0; i < 4; i++) begin
        exp_a.push_back(w[8*i +: 8]);
        exp_b.push_back(w[8*(3-i) +: 8]);
      end
      fetch_pending = 1'b1;
    end
    fifo_empty = (word_q.size() == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, 32'({rd_a, rd_b}), 32'(0));
    check_eq({tag, "_valid"}, 32'({val_a, val_b}), 32'(0));
    check_eq({tag, "_data"}, 32'({data_a, data_b}), 32'(0));
    check_eq({tag, "_busy"}, 32'({busy_a, busy_b}), 32'(0));
    check_eq({tag, "_cnt"}, {cnt_a, cnt_b}, 32'(0));
`ifdef WORD_SERIALIZER_PARITY_EN
    check_eq({tag, "_parity"}, 32'({par_a, par_b}), 32'(0));
`endif
  endtask

  // Asynchronous reset between edges; anything in flight is discarded.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bytes_left    = 0;
    fetch_pending = 1'b0;
    cnt_m         = '0;
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    #1;
    check_eq("rd_en_in_reset", 32'({rd_a, rd_b}), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a word already waiting upstream.
    push_word(32'hDDCCBBAA);
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Single word in both byte orders, then idle.
    repeat (8) step();

    // Two queued words back to back; includes 0x07 and 0x03 bytes for parity.
    push_word(32'h03070307);
    push_word(32'h87654321);
    repeat (14) step();

    // Stall for three cycles on byte index 1.
    push_word(32'h55667788);
    repeat (3) step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (5) step();

    // Reset after the second byte; the next word must start fresh.
    push_word(32'h44332211);
    repeat (4) step();
    push_word(32'hA5A5F00F);
    pulse_reset();
    repeat (8) step();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (word_q.size() < 3 && $urandom_range(0, 2) == 0) begin
        push_word($urandom());
      end
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
